// File: rtl/pwm_multi_button_pkg.sv
// pwm_multi_button_pkg: shared button indices, width-derived constants and saturating helpers
package pwm_multi_button_pkg;
  typedef enum logic [2:0] {
    BT_INC_DUTY,
    BT_DEC_DUTY,
    BT_INC_FREQ,
    BT_DEC_FREQ,
    BT_CH_SEL
  } bt_e;
  localparam int NUM_BT = 5;
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic int sat_add(input int a, input int b, input int hi);
    return (a + b > hi) ? hi : a + b;
  endfunction
  function automatic int sat_sub(input int a, input int b, input int lo);
    return (a - b < lo) ? lo : a - b;
  endfunction
endpackage

// File: rtl/pwm_multi_button_debounce.sv
// pwm_multi_button_debounce: 2-flop sync, stability counter and one-cycle press pulse
module pwm_multi_button_debounce #(
  parameter int DB_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);
  localparam int DW = $clog2(DB_CYC);
  logic [1:0]    r_sync;
  logic          r_level;
  logic [DW-1:0] r_cnt;
  logic          w_accept;
  assign w_accept = (r_sync[1] != r_level) && (r_cnt == DW'(DB_CYC - 1));
  // bring the raw button into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[0], i_btn};
  end
  // accept a new level after DB_CYC equal samples; pulse once on an accepted rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      o_press <= 1'b0;
    end else begin
      r_cnt   <= (r_sync[1] == r_level || w_accept) ? '0 : r_cnt + DW'(1);
      r_level <= w_accept ? r_sync[1] : r_level;
      o_press <= w_accept && r_sync[1];
    end
  end
endmodule

// File: rtl/pwm_multi_button.sv
// pwm_multi_button: N-channel PWM with button-driven, double-buffered duty and period
module pwm_multi_button
  import pwm_multi_button_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int DB_CYC    = 8,
  parameter int DUTY_STEP = 1,
  parameter int PER_STEP  = 1,
  parameter int PER_MIN   = 2,
  parameter int PER_RST   = 8,
  parameter int DUTY_RST  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc_duty_bt,
  input  logic                      dec_duty_bt,
  input  logic                      inc_freq_bt,
  input  logic                      dec_freq_bt,
  input  logic                      ch_sel_bt,
  input  logic [NUM_CH-1:0]         ch_en,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic [$clog2(NUM_CH):0]   sel_ch,
  output logic [CNT_W-1:0]          sel_duty,
  output logic [CNT_W-1:0]          sel_period
);
  localparam int SEL_W = $clog2(NUM_CH) + 1;
  localparam int MAXV  = cnt_max(CNT_W);
  logic [NUM_BT-1:0] w_raw;
  logic [NUM_BT-1:0] w_press;
  logic [SEL_W-1:0]  r_sel;
  logic [CNT_W-1:0]  w_duty_act [NUM_CH];
  logic [CNT_W-1:0]  w_per_act  [NUM_CH];
  assign w_raw  = {ch_sel_bt, dec_freq_bt, inc_freq_bt, dec_duty_bt, inc_duty_bt};
  assign sel_ch = r_sel;
  for (genvar b = 0; b < NUM_BT; b++) begin : g_bt
    pwm_multi_button_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (w_raw[b]),
      .o_press(w_press[b])
    );
  end
  // channel select steps on each accepted press and wraps at NUM_CH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sel <= '0;
    else if (w_press[BT_CH_SEL]) r_sel <= (r_sel == SEL_W'(NUM_CH - 1)) ? '0 : r_sel + SEL_W'(1);
  end
  // readback of the selected channel's active settings
  always_comb begin
    sel_duty   = '0;
    sel_period = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel == SEL_W'(i)) begin
        sel_duty   = w_duty_act[i];
        sel_period = w_per_act[i];
      end
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_duty_sh;
    logic [CNT_W-1:0] r_per_sh;
    logic [CNT_W-1:0] r_duty_act;
    logic [CNT_W-1:0] r_per_act;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwm;
    logic             w_hit;
    logic             w_last;
    logic             w_load;
    int               w_p;
    int               w_d0;
    int               w_d;
    assign w_hit  = (r_sel == SEL_W'(c));
    assign w_last = ({1'b0, r_cnt} + (CNT_W + 1)'(1)) >= {1'b0, r_per_act};
    assign w_load = ch_en[c] ? w_last : (r_cnt == '0);
    // new period first, then duty clamped to it and stepped inside [0, period]
    always_comb begin
      w_p  = (w_press[BT_INC_FREQ] && !w_press[BT_DEC_FREQ]) ? sat_sub(int'(r_per_sh), PER_STEP, PER_MIN) :
             (w_press[BT_DEC_FREQ] && !w_press[BT_INC_FREQ]) ? sat_add(int'(r_per_sh), PER_STEP, MAXV) :
             int'(r_per_sh);
      w_d0 = (int'(r_duty_sh) > w_p) ? w_p : int'(r_duty_sh);
      w_d  = (w_press[BT_INC_DUTY] && !w_press[BT_DEC_DUTY]) ? sat_add(w_d0, DUTY_STEP, w_p) :
             (w_press[BT_DEC_DUTY] && !w_press[BT_INC_DUTY]) ? sat_sub(w_d0, DUTY_STEP, 0) :
             w_d0;
    end
    // shadow settings follow button updates only while this channel is selected
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_duty_sh <= CNT_W'(DUTY_RST);
        r_per_sh  <= CNT_W'(PER_RST);
      end else if (w_hit) begin
        r_duty_sh <= CNT_W'(w_d);
        r_per_sh  <= CNT_W'(w_p);
      end
    end
    // period counter, boundary transfer of shadow to active, and registered compare
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt      <= '0;
        r_duty_act <= CNT_W'(DUTY_RST);
        r_per_act  <= CNT_W'(PER_RST);
        r_pwm      <= 1'b0;
      end else begin
        r_cnt      <= (!ch_en[c] || w_last) ? '0 : r_cnt + CNT_W'(1);
        r_duty_act <= w_load ? r_duty_sh : r_duty_act;
        r_per_act  <= w_load ? r_per_sh : r_per_act;
        r_pwm      <= ch_en[c] && (r_cnt < r_duty_act);
      end
    end
    assign pwm_out[c]    = r_pwm;
    assign w_duty_act[c] = r_duty_act;
    assign w_per_act[c]  = r_per_act;
  end
endmodule

// File: tb/tb_pwm_multi_button.sv
// tb_pwm_multi_button: scoreboard bench with a settings-level reference model
module tb_pwm_multi_button;
  localparam int NUM_CH   = 4;
  localparam int PER_MIN  = 2;
  localparam int PER_MAX  = 255;
  localparam int DUTY_RST = 4;
  localparam int PER_RST  = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inc_duty_bt = 1'b0;
  logic dec_duty_bt = 1'b0;
  logic inc_freq_bt = 1'b0;
  logic dec_freq_bt = 1'b0;
  logic ch_sel_bt = 1'b0;
  logic [NUM_CH-1:0] ch_en = '1;
  logic [NUM_CH-1:0] pwm_out;
  logic [2:0] sel_ch;
  logic [7:0] sel_duty;
  logic [7:0] sel_period;
  int n_checks = 0;
  int n_fail = 0;
  int m_duty [NUM_CH];
  int m_per  [NUM_CH];
  int m_sel;
  logic [18:0] m_last;
  logic [18:0] q [$];

  pwm_multi_button dut (
    .clk        (clk),
    .rst        (rst),
    .inc_duty_bt(inc_duty_bt),
    .dec_duty_bt(dec_duty_bt),
    .inc_freq_bt(inc_freq_bt),
    .dec_freq_bt(dec_freq_bt),
    .ch_sel_bt  (ch_sel_bt),
    .ch_en      (ch_en),
    .pwm_out    (pwm_out),
    .sel_ch     (sel_ch),
    .sel_duty   (sel_duty),
    .sel_period (sel_period)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [18:0] tup(input int s, input int d, input int p);
    return {3'(s), 8'(d), 8'(p)};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_duty[i] = DUTY_RST;
      m_per[i]  = PER_RST;
    end
    m_sel  = 0;
    m_last = tup(0, DUTY_RST, PER_RST);
  endtask

  // m bits: 0 inc_duty, 1 dec_duty, 2 inc_freq, 3 dec_freq, 4 ch_sel
  task automatic model_press(input logic [4:0] m);
    int s, p, d;
    logic [18:0] t;
    s = m_sel;
    p = m_per[s];
    if (m[2] && !m[3]) p = (p - 1 < PER_MIN) ? PER_MIN : p - 1;
    if (m[3] && !m[2]) p = (p + 1 > PER_MAX) ? PER_MAX : p + 1;
    d = (m_duty[s] < p) ? m_duty[s] : p;
    if (m[0] && !m[1]) d = (d + 1 > p) ? p : d + 1;
    if (m[1] && !m[0]) d = (d > 0) ? d - 1 : 0;
    m_per[s]  = p;
    m_duty[s] = d;
    if (m[4]) m_sel = (m_sel + 1) % NUM_CH;
    t = tup(m_sel, m_duty[m_sel], m_per[m_sel]);
    if (t != m_last) begin
      q.push_back(t);
      m_last = t;
    end
  endtask

  task automatic drive(input logic [4:0] m);
    {ch_sel_bt, dec_freq_bt, inc_freq_bt, dec_duty_bt, inc_duty_bt} = m;
  endtask

  function automatic int max_per();
    int mx = 0;
    for (int i = 0; i < NUM_CH; i++) mx = (m_per[i] > mx) ? m_per[i] : mx;
    return mx;
  endfunction

  task automatic press(input logic [4:0] m);
    int w;
    w = max_per();
    model_press(m);
    w = (max_per() > w) ? max_per() : w;
    @(negedge clk);
    drive(m);
    repeat (16) @(negedge clk);
    drive(5'd0);
    repeat (16 + w + 4) @(negedge clk);
    check("sel_ch", int'(sel_ch), m_sel);
    check("sel_duty", int'(sel_duty), m_duty[m_sel]);
    check("sel_period", int'(sel_period), m_per[m_sel]);
  endtask

  task automatic press_n(input logic [4:0] m, input int n);
    for (int k = 0; k < n; k++) press(m);
  endtask

  // high cycles over two whole periods of each channel equal twice its duty
  task automatic measure(input string tag);
    int hi [NUM_CH];
    int mx;
    mx = 2 * max_per();
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    for (int k = 0; k < mx; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) if (k < 2 * m_per[i] && pwm_out[i]) hi[i]++;
    end
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("%s pwm%0d highs", tag, i), hi[i], ch_en[i] ? 2 * m_duty[i] : 0);
  endtask

  // monitor: every readback change must match the next queued expectation
  initial begin
    logic [18:0] cur, last, exp;
    last = tup(0, DUTY_RST, PER_RST);
    forever begin
      @(negedge clk);
      cur = {sel_ch, sel_duty, sel_period};
      if (!rst) last = tup(0, DUTY_RST, PER_RST);
      else if (cur != last) begin
        if (q.size() == 0) check("unexpected readback change", int'(cur), int'(last));
        else begin
          exp = q.pop_front();
          check("readback", int'(cur), int'(exp));
        end
        last = cur;
      end
    end
  end

  initial begin
    model_reset();
    // T1 reset
    repeat (3) @(negedge clk);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset sel_ch", int'(sel_ch), 0);
    check("reset sel_duty", int'(sel_duty), DUTY_RST);
    check("reset sel_period", int'(sel_period), PER_RST);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    measure("T1");
    // T2 debounce
    inc_duty_bt = 1'b1;
    repeat (3) @(negedge clk);
    inc_duty_bt = 1'b0;
    repeat (30) @(negedge clk);
    check("T2 glitch ignored", int'(sel_duty), 4);
    press(5'b00001);
    check("T2 duty after press", int'(sel_duty), 5);
    // T3 saturation
    press_n(5'b00001, 6);
    check("T3 duty max", int'(sel_duty), 8);
    measure("T3 full");
    press_n(5'b00010, 10);
    check("T3 duty min", int'(sel_duty), 0);
    measure("T3 zero");
    // T4 period clamp
    press_n(5'b00001, 6);
    press_n(5'b00100, 7);
    check("T4 period min", int'(sel_period), PER_MIN);
    check("T4 duty clamp", int'(sel_duty), PER_MIN);
    measure("T4");
    // T5 channel select
    press(5'b10000);
    press_n(5'b01000, 2);
    check("T5 ch1 period", int'(sel_period), 10);
    press_n(5'b10000, 3);
    press_n(5'b10000, 4);
    check("T5 sel wrap", int'(sel_ch), 0);
    measure("T5");
    // randomized presses and enables
    for (int n = 0; n < 40; n++) begin
      logic [4:0] m;
      m = ($urandom_range(0, 9) < 7) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom_range(1, 31));
      press(m);
      if (n % 8 == 7) begin
        ch_en = 4'($urandom_range(0, 15));
        repeat (4) @(negedge clk);
        measure("rand");
      end
    end
    ch_en = '1;
    // T6 boundary, enable and mid-period reset
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    model_press(5'b00001);
    ch_en[0] = 1'b0;
    repeat (3) @(negedge clk);
    ch_en[0] = 1'b1;
    inc_duty_bt = 1'b1;
    repeat (13) @(negedge clk);
    check("T6 old duty mid-period", int'(sel_duty), 4);
    repeat (2) @(negedge clk);
    check("T6 old duty before wrap", int'(sel_duty), 4);
    @(negedge clk);
    check("T6 new duty at wrap", int'(sel_duty), 5);
    inc_duty_bt = 1'b0;
    repeat (30) @(negedge clk);
    ch_en[2] = 1'b0;
    @(negedge clk);
    check("T6 ch2 disabled", int'(pwm_out[2]), 0);
    repeat (3) @(negedge clk);
    measure("T6");
    ch_en = '1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("T6 async reset pwm_out", int'(pwm_out), 0);
    check("T6 async reset sel_duty", int'(sel_duty), DUTY_RST);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    measure("T6 post reset");
    check("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
